// File: rtl/bcd_seg7_scan_counter.sv
// -----------------------------------------------------------------------------
// bcd_seg7_scan_counter
//
// Purpose:
//   Four-digit BCD up/down counter with a built-in scanner for a multiplexed
//   common-anode seven-segment display. The count advances once per rising
//   edge of tick_in, which comes from clk_divider. Everything runs on
//   clock_in, so no second clock domain exists.
//
// Parameters:
//   SCAN_DIV  number of clock_in cycles each digit stays lit (2 .. 2^20-1)
//
// Ports:
//   clock_in   in   1   board clock, the only clock of the block
//   reset_n    in   1   asynchronous, active-low reset
//   tick_in    in   1   divided clock, synchronous to clock_in
//   enable     in   1   1 = tick edges step the count, 0 = edges ignored
//   up_down    in   1   1 = count up, 0 = count down (sampled on step cycle)
//   clear      in   1   synchronous clear of the count (beats a step)
//   count_bcd  out  16  {d3,d2,d1,d0} registered BCD count
//   wrap       out  1   one-cycle pulse on 9999->0000 or 0000->9999
//   an         out  4   digit anodes, active-low, an[0] = d0
//   seg        out  7   cathodes {g,f,e,d,c,b,a}, active-low
//   dp         out  1   decimal point, active-low, held off (1)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most-significant
//                          nonzero digit are blanked (d0 always shown).
// -----------------------------------------------------------------------------
module bcd_seg7_scan_counter #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic        tick_in,
    input  logic        enable,
    input  logic        up_down,
    input  logic        clear,
    output logic [15:0] count_bcd,
    output logic        wrap,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [19:0] SCAN_LAST = 20'(SCAN_DIV - 1);

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    // Returns {carry_out, incremented value}; carry_out is set only when
    // every digit was 9, i.e. on the 9999 -> 0000 roll.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Returns {borrow_out, decremented value}; borrow_out is set only on
    // the 0000 -> 9999 roll.
    function automatic logic [16:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    // Active-low gfedcba; codes 10..15 never occur and show blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Tick edge detect and counter
    // ------------------------------------------------------------------
    logic        tick_q;
    logic        step;
    logic [16:0] inc_res;
    logic [16:0] dec_res;

    assign step    = tick_in & ~tick_q & enable;
    assign inc_res = bcd_inc(count_bcd);
    assign dec_res = bcd_dec(count_bcd);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            tick_q    <= 1'b0;
            count_bcd <= 16'h0000;
            wrap      <= 1'b0;
        end else begin
            // tick_q follows tick_in even during clear, so an edge that
            // coincides with clear is swallowed rather than replayed later.
            tick_q <= tick_in;
            if (clear) begin
                count_bcd <= 16'h0000;
                wrap      <= 1'b0;
            end else if (step) begin
                if (up_down) begin
                    count_bcd <= inc_res[15:0];
                    wrap      <= inc_res[16];
                end else begin
                    count_bcd <= dec_res[15:0];
                    wrap      <= dec_res[16];
                end
            end else begin
                wrap <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    logic [19:0] scan_cnt;
    logic [1:0]  idx;
    logic [3:0]  digit_sel;
    logic [6:0]  seg_next;

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] lz_blank;
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (count_bcd[15:12] == 4'd0);
        lz_blank[2] = lz_blank[3] && (count_bcd[11:8] == 4'd0);
        lz_blank[1] = lz_blank[2] && (count_bcd[7:4] == 4'd0);
    end
`endif

    always_comb begin
        digit_sel = count_bcd[3:0];
        case (idx)
            2'd0:    digit_sel = count_bcd[3:0];
            2'd1:    digit_sel = count_bcd[7:4];
            2'd2:    digit_sel = count_bcd[11:8];
            default: digit_sel = count_bcd[15:12];
        endcase
        seg_next = seg_decode(digit_sel);
`ifdef LEADING_ZERO_BLANK_EN
        if (lz_blank[idx]) begin
            seg_next = 7'h7F;
        end
`endif
    end

    // an and seg share one register stage so they always refer to the
    // same digit; the lit digit lags count_bcd by one cycle.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt <= 20'd0;
            idx      <= 2'd0;
            an       <= 4'b1111;
            seg      <= 7'h7F;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= 20'd0;
                idx      <= idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 20'd1;
            end
            an  <= ~(4'b0001 << idx);
            seg <= seg_next;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_scan_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg7_scan_counter
//
// Self-checking bench. Count updates are predicted by a decimal model and
// queued; an independent monitor pops an entry every time count_bcd moves.
// Scan patterns and reset values are checked against hand-computed tables.
// -----------------------------------------------------------------------------
module tb_bcd_seg7_scan_counter;

    localparam int unsigned SCAN_DIV = 4;

    logic        clock_in;
    logic        reset_n;
    logic        tick_in;
    logic        enable;
    logic        up_down;
    logic        clear;
    logic [15:0] count_bcd;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int tests  = 0;
    int failed = 0;
    int model  = 0;

    logic [16:0] exp_q[$];
    logic [15:0] prev_cnt;

    bcd_seg7_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .tick_in   (tick_in),
        .enable    (enable),
        .up_down   (up_down),
        .clear     (clear),
        .count_bcd (count_bcd),
        .wrap      (wrap),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    // ---------------- clock / watchdog ----------------
    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // One tick_in pulse held high for high_cyc rising edges.
    task automatic tick_pulse(input int high_cyc);
        logic w;
        int   nv;
        if (enable) begin
            if (up_down) begin
                w  = (model == 9999);
                nv = w ? 0 : model + 1;
            end else begin
                w  = (model == 0);
                nv = w ? 9999 : model - 1;
            end
            model = nv;
            exp_q.push_back({w, to_bcd(nv)});
        end
        @(posedge clock_in); #1 tick_in = 1'b1;
        repeat (high_cyc) @(posedge clock_in);
        #1 tick_in = 1'b0;
        repeat (2) @(posedge clock_in);
    endtask

    task automatic do_clear(input bit with_tick);
        if (model != 0) exp_q.push_back({1'b0, 16'h0000});
        model = 0;
        @(posedge clock_in); #1;
        clear = 1'b1;
        if (with_tick) tick_in = 1'b1;
        @(posedge clock_in); #1 clear = 1'b0;
        repeat (3) @(posedge clock_in);
        #1 tick_in = 1'b0;
        repeat (2) @(posedge clock_in);
    endtask

    // Find the negedge where the scanner just moved from digit 3 to digit 0.
    task automatic wait_phase0(output bit ok);
        logic [3:0] last_an;
        ok = 1'b0;
        @(negedge clock_in);
        last_an = an;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clock_in);
            if (an == 4'b1110 && last_an == 4'b0111) ok = 1'b1;
            last_an = an;
        end
    endtask

    task automatic scan_check(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        bit         ok;
        logic [3:0] an_tab[4];
        logic [6:0] seg_tab[4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{s0, s1, s2, s3};
        wait_phase0(ok);
        check({name, "_sync"}, 32'(ok), 32'd1);
        if (ok) begin
            for (int k = 0; k < 32; k++) begin
                if (k != 0) @(negedge clock_in);
                check({name, "_an"},  32'(an),  32'(an_tab[(k / SCAN_DIV) % 4]));
                check({name, "_seg"}, 32'(seg), 32'(seg_tab[(k / SCAN_DIV) % 4]));
            end
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock_in) begin
        if (!reset_n) begin
            prev_cnt = count_bcd;
        end else begin
            if (count_bcd !== prev_cnt) begin
                tests++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL count_unexpected: got %0h wrap %0b expected no change from %0h",
                             count_bcd, wrap, prev_cnt);
                end else begin
                    logic [16:0] e;
                    e = exp_q.pop_front();
                    if ({wrap, count_bcd} !== e) begin
                        failed++;
                        $display("FAIL count_step: got wrap %0b count %0h expected wrap %0b count %0h",
                                 wrap, count_bcd, e[16], e[15:0]);
                    end
                end
            end else if (wrap === 1'b1) begin
                tests++;
                failed++;
                $display("FAIL wrap_extra: got wrap 1 with count %0h expected 0", count_bcd);
            end
            prev_cnt = count_bcd;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset_n  = 1'b0;
        tick_in  = 1'b0;
        enable   = 1'b0;
        up_down  = 1'b1;
        clear    = 1'b0;
        prev_cnt = 16'h0000;

        // reset values
        #12;
        check("rst_an",    32'(an),        32'hF);
        check("rst_seg",   32'(seg),       32'h7F);
        check("rst_dp",    32'(dp),        32'h1);
        check("rst_count", 32'(count_bcd), 32'h0);
        check("rst_wrap",  32'(wrap),      32'h0);
        @(negedge clock_in); #1 reset_n = 1'b1;
        @(posedge clock_in); #1;
        check("rel_an", 32'(an), 32'hE);

        // ten long tick pulses, counting up
        enable  = 1'b1;
        up_down = 1'b1;
        for (int i = 0; i < 10; i++) tick_pulse(5);
        check("up10_count", 32'(count_bcd), 32'h0010);

        // enable low: edges ignored
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick_pulse(2);
        check("dis_count", 32'(count_bcd), 32'h0010);

        // clear with coincident tick edge: edge consumed
        enable = 1'b1;
        do_clear(1'b1);
        check("clr_count", 32'(count_bcd), 32'h0000);

        // down wrap then up wrap
        up_down = 1'b0;
        tick_pulse(1);
        check("down_wrap_count", 32'(count_bcd), 32'h9999);
        up_down = 1'b1;
        tick_pulse(1);
        check("up_wrap_count", 32'(count_bcd), 32'h0000);

        // asynchronous reset mid-count
        for (int i = 0; i < 3; i++) tick_pulse(1);
        check("pre_rst_count", 32'(count_bcd), 32'h0003);
        @(posedge clock_in); #3 reset_n = 1'b0;
        #1;
        check("mid_rst_an",    32'(an),        32'hF);
        check("mid_rst_seg",   32'(seg),       32'h7F);
        check("mid_rst_dp",    32'(dp),        32'h1);
        check("mid_rst_count", 32'(count_bcd), 32'h0);
        check("mid_rst_wrap",  32'(wrap),      32'h0);
        model = 0;
        @(negedge clock_in); #1 reset_n = 1'b1;
        @(posedge clock_in); #1;
        check("mid_rel_an", 32'(an), 32'hE);

        // count to 1234 and check the scan sequence
        for (int i = 0; i < 1234; i++) tick_pulse(1);
        check("cnt1234", 32'(count_bcd), 32'h1234);
        scan_check("scan1234", 7'h19, 7'h30, 7'h24, 7'h79);

        // 0007 display
        do_clear(1'b0);
        for (int i = 0; i < 7; i++) tick_pulse(1);
        check("cnt0007", 32'(count_bcd), 32'h0007);
`ifdef LEADING_ZERO_BLANK_EN
        scan_check("scan0007", 7'h78, 7'h7F, 7'h7F, 7'h7F);
`else
        scan_check("scan0007", 7'h78, 7'h40, 7'h40, 7'h40);
`endif

        repeat (4) @(negedge clock_in);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
